// File: rtl/pieo_enq_tracker_pkg.sv
// Shared types and helpers for the PIEO enqueue tracker.
// FSM states, FIFO id type, and round-robin pointer arithmetic.
package pieo_enq_tracker_pkg;

  localparam int DEF_NUM_FIFO = 3;
  localparam int DEF_ID_LOG   = 2;

  typedef logic [DEF_ID_LOG-1:0] fifo_id_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  function automatic int rr_next(
    input int cur,
    input int num
  );
    return (cur + 1 >= num) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/pieo_enq_tracker_rr_pick_first.sv
// Rotate-priority encoder: first set request at or above start,
// wrapping past NUM_FIFO-1 back to 0.
module rr_pick_first #(
  parameter int NUM_FIFO = 3,
  parameter int ID_LOG   = 2
) (
  input  logic [NUM_FIFO-1:0] req,
  input  logic [ID_LOG-1:0]   start,
  output logic                found,
  output logic [ID_LOG-1:0]   idx
);

  localparam logic [ID_LOG:0] NF = (ID_LOG+1)'(NUM_FIFO);

  // scan NUM_FIFO positions starting at start, keep the first hit
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      automatic logic [ID_LOG:0] s;
      automatic logic [ID_LOG-1:0] j;
      s = {1'b0, start} + (ID_LOG+1)'(k);
      if (s >= NF) s = s - NF;
      j = ID_LOG'(s);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/pieo_enq_tracker.sv
// Round-robin enqueue scheduler sharing one PIEO enqueue port.
// Tracks resident flows so each has at most one element in flight.
module pieo_enq_tracker
  import pieo_enq_tracker_pkg::*;
#(
  parameter int NUM_FIFO = DEF_NUM_FIFO,
  parameter int ID_LOG   = DEF_ID_LOG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_FIFO-1:0] fifo_not_empty,
  input  logic                pieo_enq_trigger,
  input  logic                pieo_deq_valid,
  input  logic [ID_LOG-1:0]   pieo_deq_fifo_id,
  output logic                fifos_not_enq_flag,
  output logic [ID_LOG-1:0]   fifo_id,
  output logic [NUM_FIFO-1:0] in_pieo,
  output logic [ID_LOG:0]     in_pieo_count,
  output logic                err
);

  localparam logic [ID_LOG:0] NF = (ID_LOG+1)'(NUM_FIFO);

  state_e              state;
  state_e              state_nxt;
  logic [ID_LOG-1:0]   rr_ptr;
  logic [ID_LOG-1:0]   rr_nxt;
  logic [ID_LOG-1:0]   id_nxt;
  logic                flag_nxt;
  logic [NUM_FIFO-1:0] eligible;
  logic [NUM_FIFO-1:0] in_nxt;
  logic [ID_LOG:0]     cnt_nxt;
  logic                err_nxt;
  logic                found;
  logic [ID_LOG-1:0]   pick;
  logic                enq_fire;

  assign eligible = fifo_not_empty & ~in_pieo;
  assign enq_fire = (state == ST_OFFER) && pieo_enq_trigger;

  rr_pick_first #(
    .NUM_FIFO (NUM_FIFO),
    .ID_LOG   (ID_LOG)
  ) u_pick (
    .req   (eligible),
    .start (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  // residency bitmap: set on enqueue first, then clear on dequeue
  always_comb begin
    in_nxt  = in_pieo;
    err_nxt = err;
    cnt_nxt = '0;
    if (pieo_enq_trigger && state != ST_OFFER) err_nxt = 1'b1;
    if (enq_fire) in_nxt[fifo_id] = 1'b1;
    if (pieo_deq_valid) begin
      if ({1'b0, pieo_deq_fifo_id} >= NF) begin
        err_nxt = 1'b1;
      end else begin
        if (!in_pieo[pieo_deq_fifo_id]) err_nxt = 1'b1;
        in_nxt[pieo_deq_fifo_id] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_FIFO; i++) begin
      cnt_nxt = cnt_nxt + (ID_LOG+1)'(in_nxt[i]);
    end
  end

  // offer FSM: pick in IDLE, hold in OFFER until trigger or withdraw
  always_comb begin
    state_nxt = state;
    flag_nxt  = fifos_not_enq_flag;
    id_nxt    = fifo_id;
    rr_nxt    = rr_ptr;
    unique case (state)
      ST_IDLE: begin
        flag_nxt = 1'b0;
        if (found) begin
          state_nxt = ST_OFFER;
          flag_nxt  = 1'b1;
          id_nxt    = pick;
        end
      end
      ST_OFFER: begin
        if (pieo_enq_trigger) begin
          state_nxt = ST_IDLE;
          flag_nxt  = 1'b0;
          rr_nxt    = ID_LOG'(rr_next(int'(fifo_id), NUM_FIFO));
        end else if (!fifo_not_empty[fifo_id]) begin
          state_nxt = ST_IDLE;
          flag_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        flag_nxt  = 1'b0;
      end
    endcase
  end

  // state, pointer, offer, bitmap, count and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      rr_ptr             <= '0;
      fifos_not_enq_flag <= 1'b0;
      fifo_id            <= '0;
      in_pieo            <= '0;
      in_pieo_count      <= '0;
      err                <= 1'b0;
    end else begin
      state              <= state_nxt;
      rr_ptr             <= rr_nxt;
      fifos_not_enq_flag <= flag_nxt;
      fifo_id            <= id_nxt;
      in_pieo            <= in_nxt;
      in_pieo_count      <= cnt_nxt;
      err                <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pieo_enq_tracker.sv
// Self-checking bench for pieo_enq_tracker.
// Expected offer ids are queued and popped as offers appear.
module tb_pieo_enq_tracker;

  localparam int NF = 3;
  localparam int IL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] fne = '0;
  logic          trig = 1'b0;
  logic          dv = 1'b0;
  logic [IL-1:0] did = '0;
  logic          flag;
  logic [IL-1:0] fid;
  logic [NF-1:0] inp;
  logic [IL:0]   cnt;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pieo_enq_tracker #(
    .NUM_FIFO (NF),
    .ID_LOG   (IL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_not_empty     (fne),
    .pieo_enq_trigger   (trig),
    .pieo_deq_valid     (dv),
    .pieo_deq_fifo_id   (did),
    .fifos_not_enq_flag (flag),
    .fifo_id            (fid),
    .in_pieo            (inp),
    .in_pieo_count      (cnt),
    .err                (err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    fne  = '0;
    trig = 1'b0;
    dv   = 1'b0;
    did  = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_offer();
    for (int i = 0; i < 20; i++) begin
      if (flag) return;
      step();
    end
    chk("offer_timeout", 0, 1);
  endtask

  task automatic enq_one();
    wait_offer();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  initial begin
    // reset, then single flow
    do_reset();
    chk("rst_flag", int'(flag), 0);
    chk("rst_id", int'(fid), 0);
    chk("rst_inp", int'(inp), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_err", int'(err), 0);
    fne = 3'b010;
    step();
    chk("s_flag", int'(flag), 1);
    chk("s_id", int'(fid), 1);
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("s_inp", int'(inp), 2);
    chk("s_cnt", int'(cnt), 1);
    chk("s_flag_clr", int'(flag), 0);
    step();
    step();
    chk("s_flag_stay", int'(flag), 0);

    // round robin with immediate dequeue
    do_reset();
    fne = 3'b111;
    for (int k = 0; k < 6; k++) exp_q.push_back(k % 3);
    while (exp_q.size() > 0) begin
      automatic int e;
      automatic logic [IL-1:0] cur;
      wait_offer();
      e = exp_q.pop_front();
      chk("rr_order", int'(fid), e);
      cur  = fid;
      trig = 1'b1;
      step();
      trig = 1'b0;
      dv   = 1'b1;
      did  = cur;
      step();
      dv = 1'b0;
    end
    chk("rr_err", int'(err), 0);

    // hold and withdraw
    do_reset();
    fne = 3'b100;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("hold_id", int'(fid), 2);
      chk("hold_flag", int'(flag), 1);
      step();
    end
    fne = 3'b011;
    step();
    chk("wd_flag", int'(flag), 0);
    step();
    chk("wd_reoffer_flag", int'(flag), 1);
    chk("wd_reoffer_id", int'(fid), 0);

    // all resident, then dequeue id 1
    do_reset();
    fne = 3'b111;
    enq_one();
    enq_one();
    enq_one();
    step();
    step();
    chk("all_cnt", int'(cnt), 3);
    chk("all_inp", int'(inp), 7);
    chk("all_noflag", int'(flag), 0);
    dv  = 1'b1;
    did = 2'd1;
    step();
    dv = 1'b0;
    chk("deq_cnt", int'(cnt), 2);
    chk("deq_flag_n", int'(flag), 0);
    step();
    chk("deq_flag_n1", int'(flag), 1);
    chk("deq_id_n1", int'(fid), 1);

    // simultaneous enqueue of 0 and dequeue of 2
    do_reset();
    fne = 3'b100;
    enq_one();
    fne = 3'b101;
    step();
    chk("sim_pre_inp", int'(inp), 4);
    chk("sim_pre_id", int'(fid), 0);
    chk("sim_pre_flag", int'(flag), 1);
    trig = 1'b1;
    dv   = 1'b1;
    did  = 2'd2;
    step();
    trig = 1'b0;
    dv   = 1'b0;
    chk("sim_inp", int'(inp), 1);
    chk("sim_cnt", int'(cnt), 1);
    chk("sim_err", int'(err), 0);

    // errors: non-resident dequeue
    dv  = 1'b1;
    did = 2'd1;
    step();
    dv = 1'b0;
    chk("e_nr_err", int'(err), 1);
    chk("e_nr_inp", int'(inp), 1);
    step();
    chk("e_sticky", int'(err), 1);

    // errors: out-of-range id
    do_reset();
    dv  = 1'b1;
    did = 2'd3;
    step();
    dv = 1'b0;
    chk("e_oor_err", int'(err), 1);
    chk("e_oor_inp", int'(inp), 0);

    // errors: trigger with no offer
    do_reset();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("e_trig_err", int'(err), 1);
    chk("e_trig_inp", int'(inp), 0);

    // async reset mid-offer
    do_reset();
    fne = 3'b111;
    enq_one();
    wait_offer();
    chk("ar_pre_id", int'(fid), 1);
    chk("ar_pre_inp", int'(inp), 1);
    trig = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_flag", int'(flag), 0);
    chk("ar_id", int'(fid), 0);
    chk("ar_inp", int'(inp), 0);
    chk("ar_cnt", int'(cnt), 0);
    trig = 1'b0;
    step();
    rst = 1'b0;
    chk("ar_post_inp", int'(inp), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
